// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder
//   Multi-cycle ripple-carry adder. It computes sum = a + b + cin over WIDTH-bit
//   operands and adds CHUNK bits per clock, so one operation takes
//   NCH = WIDTH/CHUNK cycles. The full-width carry chain is broken into
//   CHUNK-bit slices so that it closes timing on wide datapaths.
//
//   Ports
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset
//     start  in   request; accepted only while idle (also in the done cycle)
//     a, b   in   WIDTH-bit operands, latched on acceptance
//     cin    in   carry-in, latched on acceptance
//     busy   out  operation in progress
//     done   out  one-cycle completion pulse; sum is valid from this cycle
//     sum    out  WIDTH+1 bit result, MSB is the final carry-out
//     err    out  self-check mismatch (sticky until the next accepted start)
//
//   Optional feature: define SEQ_CHUNK_ADDER_SELFCHECK_EN to compile in a
//   behavioural cross-check of the final sum. Without it, err is tied to 0.
//   The port list is the same in both builds.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic             err
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] a_l, b_l;

  logic [31:0]      base;
  logic [CHUNK:0]   csum;
  logic             last;
  logic [WIDTH:0]   sum_nxt;

  // One chunk slice per cycle. sum_nxt is the sum register with the current
  // chunk (and the carry-out on the last chunk) merged in. The self-check
  // compares against this value, so it sees the result of the completing
  // edge.
  always_comb begin
    base    = 32'(k) * CHUNK;
    csum    = {1'b0, a_l[base +: CHUNK]} + {1'b0, b_l[base +: CHUNK]}
            + {{CHUNK{1'b0}}, carry};
    last    = (k == KLAST);
    sum_nxt = sum;
    sum_nxt[base +: CHUNK] = csum[CHUNK-1:0];
    if (last) sum_nxt[WIDTH] = csum[CHUNK];
  end

`ifdef SEQ_CHUNK_ADDER_SELFCHECK_EN
  logic cin_l;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      k     <= '0;
      carry <= 1'b0;
      a_l   <= '0;
      b_l   <= '0;
`ifdef SEQ_CHUNK_ADDER_SELFCHECK_EN
      cin_l <= 1'b0;
      err   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_l   <= a;
            b_l   <= b;
            carry <= cin;
            sum   <= '0;
            k     <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef SEQ_CHUNK_ADDER_SELFCHECK_EN
            cin_l <= cin;
            err   <= 1'b0;
`endif
          end
        end
        RUN: begin
          sum   <= sum_nxt;
          carry <= csum[CHUNK];
          if (last) begin
            k     <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
`ifdef SEQ_CHUNK_ADDER_SELFCHECK_EN
            if (sum_nxt != ({1'b0, a_l} + {1'b0, b_l} + {{WIDTH{1'b0}}, cin_l}))
              err <= 1'b1;
`endif
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SEQ_CHUNK_ADDER_SELFCHECK_EN
  assign err = 1'b0;
`endif

endmodule
